uart_rx_fsm: RTL
================

# uart_rx_fsm

Oversampling UART receiver stage feeding `uart_ctrl`. It synchronises the asynchronous serial input, detects start bits, and samples each bit at mid-period using the oversample strobe from `baud_gen`. It presents each received word with a one-cycle valid pulse and flags framing errors. `busy_o` drives `baud_gen`'s `rx_busy_i`.

## Interface
- `DataWidth`, 8, data bits per frame (5..9); LSB transmitted first
- `OverSampleRate`, 16, tick_i strobes per bit period; even, ≥4
- `clk_i` in 1 system clock; all logic on rising edge
- `rst_i` in 1 reset; synchronous, active-low
- `tick_i` in 1 single-cycle oversample strobe (baudx16_tick_o from baud_gen)
- `rx_i` in 1 asynchronous serial line, idle high
- `data_o` out DataWidth last correctly framed word; held until next good frame
- `rx_dv_o` out 1 one-cycle pulse, data_o updated same cycle
- `frame_err_o` out 1 one-cycle pulse, stop bit sampled low
- `busy_o` out 1 high in any state other than IDLE

## Operation
- Synchroniser: 2 flops on rx_i, reset to 1. A third flop (`rx_prev`) holds the previous synced value for edge detection.
- Counters:
  - tick counter, width $clog2(OverSampleRate); advances only on tick_i and wraps to 0 after OverSampleRate-1.
  - bit counter, width $clog2(DataWidth+1).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Arms only on a synced falling edge (rx_prev=1, rx_sync=0).
  - On the edge: clear tick counter, go to START.
  - A line held low (break) never re-arms until it has been seen high.
- START:
  - On the tick where tick count = OverSampleRate/2-1, sample the line.
  - Line low: clear tick counter and bit counter, go to DATA.
  - Line high: false start; go to IDLE with no output pulse.
- DATA:
  - On the tick where tick count = OverSampleRate-1: shift the sampled bit into the MSB of the shift register (shift right), then increment the bit counter.
  - After DataWidth bits, go to STOP.
- STOP: on the tick where tick count = OverSampleRate-1, sample the line and go to IDLE.
  - Sample 1: data_o ← shift register, pulse rx_dv_o.
  - Sample 0: pulse frame_err_o; data_o unchanged.
- tick_i low: all counters and FSM hold. The synchroniser keeps running.
- rx_dv_o and frame_err_o are mutually exclusive.

## Timing
- Reset: data_o=0, rx_dv_o=0, frame_err_o=0, busy_o=0; state IDLE; sync flops and rx_prev = 1; counters 0.
- Start detection: START is entered 3 clk_i cycles after the rx_i falling edge (2 synchroniser flops + edge register).
- Bit sampling: each bit is sampled ~mid-bit, 1.5×OverSampleRate ticks after start detection for bit 0, then every OverSampleRate ticks.
- Output latency: rx_dv_o / frame_err_o assert in the clock after the stop-sample tick and last exactly 1 cycle.
- busy_o:
  - Rises the cycle after IDLE is left.
  - Falls the same cycle the output pulse asserts.
- Back-to-back frames: a falling edge arriving in the cycle IDLE is re-entered is accepted. The FSM samples the stop bit mid-bit, so the next start edge is never missed.
- Reset mid-frame: the frame is abandoned with no pulse. The next frame begins only on a fresh falling edge after reset release.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_e` enum (IDLE, START, DATA, STOP)
  - default constants `UartDataWidth=8`, `UartOverSampleRate=16`
  - reused by the TX and ctrl stages
- One sub-module: `sync_2ff`, a generic 2-flop synchroniser with parameterised reset value; reused by the other UART stages.

## Test plan
- Frame 0xA5, 8N1, tick_i every 4 clk -> one rx_dv_o pulse, data_o=0xA5, frame_err_o never high, busy_o low afterwards.
- Low glitch on rx_i lasting 3 ticks, line then high -> FSM returns to IDLE, no rx_dv_o or frame_err_o, data_o unchanged.
- Frame 0x3C with stop bit forced 0 -> frame_err_o pulses once, data_o keeps the previous value (0xA5), no rx_dv_o.
- Frames 0x00 then 0xFF back-to-back (no idle bits) -> two rx_dv_o pulses in order, data_o=0x00 then 0xFF.
- Line held low for 3 frame periods (break) -> exactly one frame_err_o; no further pulses until the line returns high and a new frame 0x5A is received correctly.
- rst_i asserted low for 1 cycle after bit 3 of frame 0x81 -> all outputs 0 next cycle, no pulse for that frame. A following frame 0x42 gives data_o=0x42.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default frame constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int UartDataWidth      = 8;
  localparam int UartOverSampleRate = 16;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with selectable reset value
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ff_q <= {2{ResetVal}};
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - oversampling UART receiver with mid-bit sampling and framing check
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DataWidth      = UartDataWidth,
  parameter int OverSampleRate = UartOverSampleRate
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 rx_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 rx_dv_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int TickW = $clog2(OverSampleRate);
  localparam int BitW  = $clog2(DataWidth + 1);
  localparam logic [TickW-1:0] TickMid  = TickW'(OverSampleRate / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OverSampleRate - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  rx_state_e            state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d, tick_nxt;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 rx_dv_q, rx_dv_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [1:0]           settle_q, settle_d;
  logic                 line_ok_q, line_ok_d;
  logic                 rx_sync;
  logic                 fall_edge;
  logic                 stop_tick;

  sync_2ff #(.ResetVal(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rst_i),
    .d_i    (rx_i),
    .q_o    (rx_sync)
  );

  // The synchroniser comes out of reset reading 1 regardless of the line; only a
  // genuinely observed high (after it has flushed) may arm start detection.
  assign fall_edge = line_ok_q & rx_prev_q & ~rx_sync;
  assign tick_nxt  = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
  assign stop_tick = (state_q == STOP) && tick_i && (tick_cnt_q == TickLast);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_prev_q   <= 1'b1;
      settle_q    <= '0;
      line_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      rx_prev_q   <= rx_prev_d;
      settle_q    <= settle_d;
      line_ok_q   <= line_ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_prev_d  = rx_sync;
    settle_d   = {settle_q[0], 1'b1};
    line_ok_d  = line_ok_q | (settle_q[1] & rx_sync);
    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          tick_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick_i) begin
          if (tick_cnt_q == TickMid) begin
            if (!rx_sync) begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_nxt;
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          tick_cnt_d = tick_nxt;
          if (tick_cnt_q == TickLast) begin
            shift_d   = {rx_sync, shift_q[DataWidth-1:1]};
            bit_cnt_d = bit_cnt_q + BitW'(1);
            if (bit_cnt_q == BitLast) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick_i) begin
          tick_cnt_d = tick_nxt;
          if (tick_cnt_q == TickLast) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    if (stop_tick) begin
      if (rx_sync) begin
        data_d  = shift_q;
        rx_dv_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  assign data_o      = data_q;
  assign rx_dv_o     = rx_dv_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != IDLE);

endmodule
